// File: rtl/hilo_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

   typedef enum logic [1:0] {
      MULT  = 2'b00,
      MULTU = 2'b01,
      DIV   = 2'b10,
      DIVU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } state_t;

   localparam logic [31:0] DIV0_LO        = 32'hFFFF_FFFF;
   localparam int          MULDIV_LATENCY = 33;

endpackage

// File: rtl/hilo_muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one step per cycle over a 2*WIDTH accumulator.
module muldiv_iter #(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 step,
   input  logic                 is_div,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   acc,
   output logic                 last
);

   localparam int CW = $clog2(ITERS);

   logic [WIDTH-1:0] operand;
   logic             div_mode;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH+1:0] div_diff;
   logic [2*WIDTH-1:0] acc_next;

   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = {1'b0, div_trial} - {2'b00, operand};
      acc_next  = acc;
      if (div_mode) begin
         if (!div_diff[WIDTH+1])
            acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   assign last = (count == CW'(ITERS - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         operand  <= '0;
         div_mode <= 1'b0;
         count    <= '0;
      end else if (load) begin
         acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
         operand  <= is_div ? b : a;
         div_mode <= is_div;
         count    <= '0;
      end else if (step) begin
         acc   <= acc_next;
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO owner: FSM, sign capture and fix-up, MTHI/MTLO writes, and the
// iterative multiply/divide datapath.
module hilo_muldiv
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITERS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   state_t state, state_next;

   logic             is_signed, sign1, sign2;
   logic [WIDTH-1:0] mag1, mag2;
   logic             load, step, iter_last;
   logic [2*WIDTH-1:0] acc;

   logic             div_q, sign1_q, sign2_q, div0_q;
   logic [WIDTH-1:0] op1_q;

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign is_signed = ~op[0];
   assign sign1     = is_signed & op1[WIDTH-1];
   assign sign2     = is_signed & op2[WIDTH-1];
   assign mag1      = sign1 ? -op1 : op1;
   assign mag2      = sign2 ? -op2 : op2;

   muldiv_iter #(.WIDTH(WIDTH), .ITERS(ITERS)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .step   (step),
      .is_div (op[1]),
      .a      (mag1),
      .b      (mag2),
      .acc    (acc),
      .last   (iter_last)
   );

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: if (start) begin
            load       = 1'b1;
            state_next = CALC;
         end
         CALC: begin
            step = 1'b1;
            if (iter_last) state_next = FIX;
         end
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Remainder follows the dividend sign; quotient/product follow sign1^sign2.
   always_comb begin
      prod_fix = (sign1_q ^ sign2_q) ? -acc : acc;
      quot_fix = (sign1_q ^ sign2_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = sign1_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
         div_q   <= 1'b0;
         sign1_q <= 1'b0;
         sign2_q <= 1'b0;
         div0_q  <= 1'b0;
         op1_q   <= '0;
      end else begin
         state <= state_next;
         done  <= (state == FIX);
         if (state == IDLE) begin
            if (start) begin
               div_q   <= op[1];
               sign1_q <= sign1;
               sign2_q <= sign2;
               div0_q  <= (op2 == '0);
               op1_q   <= op1;
            end else begin
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
            end
         end else if (state == FIX) begin
            if (div_q && div0_q) begin
               hi <= op1_q;
               lo <= DIV0_LO;
            end else if (div_q) begin
               hi <= rem_fix;
               lo <= quot_fix;
            end else begin
               hi <= prod_fix[2*WIDTH-1:WIDTH];
               lo <= prod_fix[WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: multiply/divide results, latency,
// MT* writes, ignored inputs while busy, and mid-operation reset.
module tb_hilo_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] op1, op2;
   logic        mthi, mtlo;
   logic [31:0] wdata;
   logic [31:0] hi, lo;
   logic        busy, done;

   int vectors = 0;
   int miscompares = 0;

   hilo_muldiv dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .op1   (op1),
      .op2   (op2),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // Launch one op and wait (bounded) for done; returns at the negedge where done is seen.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cnt, output bit got_done);
      @(negedge clk);
      start = 1'b1; op = o; op1 = a; op2 = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op1 = $urandom; op2 = $urandom;
      busy_cnt = 0;
      got_done = 1'b0;
      for (int i = 0; i < 40 && !got_done; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) got_done = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 2'b00; op1 = '0; op2 = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      vectors++;
      if ({hi, lo, busy, done} !== 66'b0) begin
         miscompares++;
         $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, need all zero", hi, lo, busy, done);
      end
   endtask

   task automatic test_mult();
      int  bc;
      bit  gd;
      logic [1:0]  ops [5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
      logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h00010000};
      logic [31:0] bs  [5] = '{32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h00000001, 32'h00010000};
      logic [31:0] eh  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'h00000001};
      logic [31:0] el  [5] = '{32'h00000001, 32'hFFFFFFF1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], bc, gd);
         vectors++;
         if (!gd || bc !== 33) begin
            miscompares++;
            $display("FAIL mult_latency[%0d]: busy_cycles=%0d done_seen=%0d, need 33 and 1", i, bc, gd);
         end
         vectors++;
         if (hi !== eh[i] || lo !== el[i]) begin
            miscompares++;
            $display("FAIL mult_result[%0d]: hi=%h lo=%h, need hi=%h lo=%h", i, hi, lo, eh[i], el[i]);
         end
         vectors++;
         if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_busy_overlap[%0d]: busy=%b with done, need 0", i, busy);
         end
         @(negedge clk);
         vectors++;
         if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width[%0d]: done=%b, need 0", i, done);
         end
      end
   endtask

   task automatic test_div();
      int  bc;
      bit  gd;
      logic [1:0]  ops [6] = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11};
      logic [31:0] as  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'hFFFFFFFB, 32'h00000064};
      logic [31:0] bs  [6] = '{32'h00000002, 32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000007};
      logic [31:0] eh  [6] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000007, 32'h00000000, 32'hFFFFFFFB, 32'h00000002};
      logic [31:0] el  [6] = '{32'hFFFFFFFD, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000000E};
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], as[i], bs[i], bc, gd);
         vectors++;
         if (!gd || bc !== 33) begin
            miscompares++;
            $display("FAIL div_latency[%0d]: busy_cycles=%0d done_seen=%0d, need 33 and 1", i, bc, gd);
         end
         vectors++;
         if (hi !== eh[i] || lo !== el[i]) begin
            miscompares++;
            $display("FAIL div_result[%0d]: hi=%h lo=%h, need hi=%h lo=%h", i, hi, lo, eh[i], el[i]);
         end
      end
   endtask

   task automatic test_ignored_while_busy();
      bit gd = 1'b0;
      int bc = 0;
      @(negedge clk);
      start = 1'b1; op = 2'b01; op1 = 32'd3; op2 = 32'd4;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= 40 && !gd; i++) begin
         @(negedge clk);
         if (busy) bc++;
         if (done) gd = 1'b1;
         mthi = (i == 5); wdata = 32'h0000DEAD;
         if (i == 6) begin
            start = 1'b1; op = 2'b01; op1 = 32'd9; op2 = 32'd9;
         end else begin
            start = 1'b0;
         end
      end
      mthi = 1'b0; start = 1'b0;
      vectors++;
      if (!gd || bc !== 33 || hi !== 32'h0 || lo !== 32'h0000000C) begin
         miscompares++;
         $display("FAIL busy_ignores_inputs: hi=%h lo=%h busy_cycles=%0d, need hi=0 lo=c 33", hi, lo, bc);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL second_start_dropped: busy=%b, need 0", busy);
      end
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h00001234;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      vectors++;
      if (hi !== 32'h00001234 || lo !== 32'h00001234) begin
         miscompares++;
         $display("FAIL mthi_mtlo_both: hi=%h lo=%h, need 00001234 both", hi, lo);
      end
      start = 1'b1; op = 2'b01; op1 = 32'd2; op2 = 32'd2;
      mthi = 1'b1; wdata = 32'h0000BEEF;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      vectors++;
      if (hi !== 32'h00001234 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL start_beats_mthi: hi=%h busy=%b, need 00001234 and 1", hi, busy);
      end
      gd = 1'b0;
      for (int i = 0; i < 40 && !gd; i++) begin
         @(negedge clk);
         if (done) gd = 1'b1;
      end
      vectors++;
      if (!gd || hi !== 32'h0 || lo !== 32'h4) begin
         miscompares++;
         $display("FAIL start_beats_mthi_result: hi=%h lo=%h, need 0 and 4", hi, lo);
      end
   endtask

   task automatic test_reset_mid_op();
      int bc;
      bit gd = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 2'b10; op1 = 32'd100; op2 = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_abort: busy=%b hi=%h lo=%h done=%b, need 0", busy, hi, lo, done);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) gd = 1'b1;
      end
      vectors++;
      if (gd !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_no_done: done_seen=%0d, need 0", gd);
      end
      run_op(2'b01, 32'd3, 32'd4, bc, gd);
      vectors++;
      if (!gd || bc !== 33 || hi !== 32'h0 || lo !== 32'h0000000C) begin
         miscompares++;
         $display("FAIL restart_after_reset: hi=%h lo=%h busy_cycles=%0d, need 0 c 33", hi, lo, bc);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_ignored_while_busy();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
